// File: rtl/sdram_bridge_pkg.sv
// Shared widths, request record and byte helper for the SDRAM port bridge.
package sdram_bridge_pkg;

  localparam int ADDR_W     = 26;
  localparam int DATA_W     = 32;
  localparam int AVM_ADDR_W = 28;
  localparam int REQ_W      = 1 + ADDR_W + DATA_W;

  typedef struct packed {
    logic              is_write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } bridge_req_t;

  function automatic logic [DATA_W-1:0] byte_rev(input logic [DATA_W-1:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/bridge_req_fifo.sv
// Request queue for the SDRAM port bridge; accepts a push in the same cycle
// the head pops even when full. No fall-through: a push is visible next cycle.
module bridge_req_fifo
  import sdram_bridge_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             push_i,
  input  logic [REQ_W-1:0] wdata_i,
  input  logic             pop_i,
  output logic [REQ_W-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [REQ_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/sdram_port_bridge.sv
// Queues datapath SDRAM requests and replays them as Avalon-MM transfers.
// Define SDRAM_BRIDGE_BYTESWAP_EN to byte-reverse write and read data.
module sdram_port_bridge
  import sdram_bridge_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_RD     = 4
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  sdram_read_en,
  input  logic                  sdram_write_en,
  input  logic [ADDR_W-1:0]     address_sdram,
  input  logic [DATA_W-1:0]     writeData_sdram,
  output logic [DATA_W-1:0]     data_sdram,
  output logic                  sdram_datareadvalid,
  output logic [AVM_ADDR_W-1:0] avm_address,
  output logic                  avm_read,
  output logic                  avm_write,
  output logic [DATA_W-1:0]     avm_writedata,
  input  logic                  avm_waitrequest,
  input  logic [DATA_W-1:0]     avm_readdata,
  input  logic                  avm_readdatavalid,
  output logic                  busy,
  output logic                  err_overflow,
  output logic                  err_protocol
);

  localparam int OUT_W = 4;

  function automatic logic [DATA_W-1:0] wr_fmt(input logic [DATA_W-1:0] d);
`ifdef SDRAM_BRIDGE_BYTESWAP_EN
    return byte_rev(d);
`else
    return d;
`endif
  endfunction

  function automatic logic [DATA_W-1:0] rd_fmt(input logic [DATA_W-1:0] d);
`ifdef SDRAM_BRIDGE_BYTESWAP_EN
    return byte_rev(d);
`else
    return d;
`endif
  endfunction

  bridge_req_t      push_req, head;
  logic [REQ_W-1:0] head_bits;
  logic             fifo_full, fifo_empty;
  logic             req_one, req_both;
  logic             rd_ok, accept, rd_accept, rd_return, stray_rdv, overflow;

  logic [OUT_W-1:0]  outstanding_q, outstanding_d;
  logic [DATA_W-1:0] data_q;
  logic              dv_q;
  logic              err_overflow_q, err_protocol_q;

  assign req_one  = sdram_read_en ^ sdram_write_en;
  assign req_both = sdram_read_en & sdram_write_en;

  assign push_req.is_write = sdram_write_en;
  assign push_req.addr     = address_sdram;
  assign push_req.data     = writeData_sdram;

  bridge_req_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .n_rst   (n_rst),
    .push_i  (req_one),
    .wdata_i (push_req),
    .pop_i   (accept),
    .rdata_o (head_bits),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head = bridge_req_t'(head_bits);

  // Head drives the bus directly; outputs are zeroed when nothing is queued.
  assign rd_ok         = (outstanding_q < OUT_W'(MAX_RD));
  assign avm_read      = !fifo_empty && !head.is_write && rd_ok;
  assign avm_write     = !fifo_empty && head.is_write;
  assign avm_address   = fifo_empty ? '0 : {head.addr, 2'b00};
  assign avm_writedata = fifo_empty ? '0 : wr_fmt(head.data);

  assign accept    = (avm_read || avm_write) && !avm_waitrequest;
  assign rd_accept = avm_read && !avm_waitrequest;
  assign rd_return = avm_readdatavalid && (outstanding_q != '0);
  assign stray_rdv = avm_readdatavalid && (outstanding_q == '0);
  assign overflow  = req_one && fifo_full && !accept;

  always_comb begin
    outstanding_d = outstanding_q;
    case ({rd_accept, rd_return})
      2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
      2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      outstanding_q  <= '0;
      data_q         <= '0;
      dv_q           <= 1'b0;
      err_overflow_q <= 1'b0;
      err_protocol_q <= 1'b0;
    end else begin
      outstanding_q  <= outstanding_d;
      dv_q           <= rd_return;
      if (rd_return) data_q <= rd_fmt(avm_readdata);
      err_overflow_q <= err_overflow_q | overflow;
      err_protocol_q <= err_protocol_q | req_both | stray_rdv;
    end
  end

  assign data_sdram          = data_q;
  assign sdram_datareadvalid = dv_q;
  assign busy                = !fifo_empty || (outstanding_q != '0);
  assign err_overflow        = err_overflow_q;
  assign err_protocol        = err_protocol_q;

endmodule

// File: tb/tb_sdram_port_bridge.sv
// Directed and randomized checks of sdram_port_bridge (FIFO_DEPTH=4, MAX_RD=2)
// against a transaction-level model of the request queue and Avalon slave.
module tb_sdram_port_bridge;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        sdram_read_en, sdram_write_en;
  logic [25:0] address_sdram;
  logic [31:0] writeData_sdram;
  logic [31:0] data_sdram;
  logic        sdram_datareadvalid;
  logic [27:0] avm_address;
  logic        avm_read, avm_write;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        busy, err_overflow, err_protocol;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sdram_port_bridge #(.FIFO_DEPTH(4), .MAX_RD(2)) dut (
    .clk                 (clk),
    .n_rst               (n_rst),
    .sdram_read_en       (sdram_read_en),
    .sdram_write_en      (sdram_write_en),
    .address_sdram       (address_sdram),
    .writeData_sdram     (writeData_sdram),
    .data_sdram          (data_sdram),
    .sdram_datareadvalid (sdram_datareadvalid),
    .avm_address         (avm_address),
    .avm_read            (avm_read),
    .avm_write           (avm_write),
    .avm_writedata       (avm_writedata),
    .avm_waitrequest     (avm_waitrequest),
    .avm_readdata        (avm_readdata),
    .avm_readdatavalid   (avm_readdatavalid),
    .busy                (busy),
    .err_overflow        (err_overflow),
    .err_protocol        (err_protocol)
  );

  function automatic logic [31:0] fmt(input logic [31:0] d);
`ifdef SDRAM_BRIDGE_BYTESWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_data"}, data_sdram, 32'h0);
    chkb({tag, "_dv"}, sdram_datareadvalid, 1'b0);
    chk({tag, "_addr"}, 32'(avm_address), 32'h0);
    chkb({tag, "_rd"}, avm_read, 1'b0);
    chkb({tag, "_wr"}, avm_write, 1'b0);
    chk({tag, "_wdata"}, avm_writedata, 32'h0);
    chkb({tag, "_busy"}, busy, 1'b0);
    chkb({tag, "_ovf"}, err_overflow, 1'b0);
    chkb({tag, "_prot"}, err_protocol, 1'b0);
  endtask

  // Transaction-level model: pending requests, reads owed by the slave.
  typedef struct { bit is_wr; int unsigned addr; int unsigned data; } mreq_t;
  typedef struct { int unsigned data; int due; } mret_t;
  mreq_t mq[$];
  mret_t rq[$];
  int          out_cnt   = 0;
  int          cyc       = 0;
  bit          exp_dv    = 0;
  logic [31:0] last_data = 32'h0;

  task automatic rcycle(input bit allow_req);
    mreq_t r;
    mret_t rt;
    bit do_rd, do_wr, exp_rd, exp_wr, acc, ret_now;
    logic [31:0] ret_data;
    chkb("rnd_dv", sdram_datareadvalid, exp_dv);
    chk("rnd_data", data_sdram, last_data);
    chkb("rnd_busy", busy, (mq.size() != 0) || (out_cnt != 0));
    do_rd = 0;
    do_wr = 0;
    if (allow_req && mq.size() < 4 && $urandom_range(0, 9) < 6) begin
      if ($urandom_range(0, 1) == 1) do_wr = 1; else do_rd = 1;
    end
    r.is_wr = do_wr;
    r.addr  = $urandom_range(0, 32'h03FF_FFFF);
    r.data  = $urandom;
    sdram_read_en   = do_rd;
    sdram_write_en  = do_wr;
    address_sdram   = r.addr[25:0];
    writeData_sdram = r.data;
    avm_waitrequest = ($urandom_range(0, 3) == 0);
    ret_now  = (rq.size() != 0) && (rq[0].due <= cyc);
    ret_data = ret_now ? rq[0].data : $urandom;
    avm_readdatavalid = ret_now;
    avm_readdata      = ret_data;
    #1;
    exp_wr = (mq.size() != 0) && mq[0].is_wr;
    exp_rd = (mq.size() != 0) && !mq[0].is_wr && (out_cnt < 2);
    chkb("rnd_avm_read", avm_read, exp_rd);
    chkb("rnd_avm_write", avm_write, exp_wr);
    if (exp_rd || exp_wr) chk("rnd_avm_addr", 32'(avm_address), mq[0].addr * 4);
    if (exp_wr) chk("rnd_avm_wdata", avm_writedata, fmt(mq[0].data));
    acc = (exp_rd || exp_wr) && !avm_waitrequest;
    if (ret_now) begin
      void'(rq.pop_front());
      out_cnt--;
    end
    if (acc) begin
      if (exp_rd) begin
        out_cnt++;
        rt.data = $urandom;
        rt.due  = cyc + 1 + int'($urandom_range(0, 3));
        rq.push_back(rt);
      end
      void'(mq.pop_front());
    end
    if (do_rd || do_wr) mq.push_back(r);
    exp_dv = ret_now;
    if (ret_now) last_data = fmt(ret_data);
    tick();
    cyc++;
  endtask

  int n;
  logic [31:0] d1, d2, d3;

  initial begin
    n_rst = 1'b0;
    sdram_read_en = 0; sdram_write_en = 0;
    address_sdram = '0; writeData_sdram = '0;
    avm_waitrequest = 0; avm_readdata = '0; avm_readdatavalid = 0;

    // Reset state
    tick(); tick(); tick();
    all_zero("reset");
    n_rst = 1'b1;

    // Single read
    sdram_read_en = 1; address_sdram = 26'h0000010;
    tick();
    sdram_read_en = 0;
    #1;
    chkb("rd1_avm_read", avm_read, 1'b1);
    chk("rd1_avm_addr", 32'(avm_address), 32'h0000040);
    tick();
    #1 chkb("rd1_read_dropped", avm_read, 1'b0);
    chkb("rd1_busy_outst", busy, 1'b1);
    tick(); tick();
    avm_readdatavalid = 1; avm_readdata = 32'hA1B2C3D4;
    #1 chkb("rd1_dv_early", sdram_datareadvalid, 1'b0);
    tick();
    avm_readdatavalid = 0;
    chkb("rd1_dv", sdram_datareadvalid, 1'b1);
`ifdef SDRAM_BRIDGE_BYTESWAP_EN
    chk("rd1_data", data_sdram, 32'hD4C3B2A1);
`else
    chk("rd1_data", data_sdram, 32'hA1B2C3D4);
`endif
    chkb("rd1_busy_end", busy, 1'b0);
    tick();
    chkb("rd1_dv_pulse", sdram_datareadvalid, 1'b0);
    chk("rd1_data_hold", data_sdram, fmt(32'hA1B2C3D4));

    // Write under stall
    sdram_write_en = 1; address_sdram = 26'd5; writeData_sdram = 32'h00FF8040;
    tick();
    sdram_write_en = 0; avm_waitrequest = 1;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) avm_waitrequest = 0;
      #1;
      chkb("wst_write", avm_write, 1'b1);
      chk("wst_addr", 32'(avm_address), 32'h14);
      chk("wst_wdata", avm_writedata, fmt(32'h00FF8040));
      chkb("wst_busy", busy, 1'b1);
      tick();
    end
    chkb("wst_busy_fall", busy, 1'b0);
    chkb("wst_write_fall", avm_write, 1'b0);

    // Queue overflow
    avm_waitrequest = 1;
    for (int i = 0; i < 6; i++) begin
      sdram_write_en = 1; address_sdram = 26'(32'h20 + i); writeData_sdram = 32'h100 + i;
      tick();
      if (i == 3) chkb("ovf_not_yet", err_overflow, 1'b0);
    end
    sdram_write_en = 0;
    chkb("ovf_flag", err_overflow, 1'b1);
    avm_waitrequest = 0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (avm_write) begin
        chk("ovf_xfer_addr", 32'(avm_address), (32'h20 + n) * 4);
        n++;
      end
      tick();
    end
    chk("ovf_xfer_count", 32'(n), 32'd4);
    chkb("ovf_sticky", err_overflow, 1'b1);
    chkb("ovf_idle", busy, 1'b0);

    // Outstanding limit
    avm_waitrequest = 1;
    for (int i = 0; i < 3; i++) begin
      sdram_read_en = 1; address_sdram = 26'(32'h100 + i);
      tick();
    end
    sdram_read_en = 0; avm_waitrequest = 0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (avm_read) n++;
      tick();
    end
    chk("lim_accepted", 32'(n), 32'd2);
    #1;
    chkb("lim_read_low", avm_read, 1'b0);
    chk("lim_head_addr", 32'(avm_address), 32'h408);
    d1 = $urandom; d2 = $urandom; d3 = $urandom;
    avm_readdatavalid = 1; avm_readdata = d1;
    tick();
    avm_readdatavalid = 0;
    chkb("lim_dv1", sdram_datareadvalid, 1'b1);
    chk("lim_data1", data_sdram, fmt(d1));
    #1 chkb("lim_third_issue", avm_read, 1'b1);
    tick();
    avm_readdatavalid = 1; avm_readdata = d2;
    tick();
    chk("lim_data2", data_sdram, fmt(d2));
    avm_readdata = d3;
    tick();
    avm_readdatavalid = 0;
    chk("lim_data3", data_sdram, fmt(d3));
    chkb("lim_busy_end", busy, 1'b0);
    chkb("lim_prot_clean", err_protocol, 1'b0);

    // Protocol errors: stray return, then simultaneous requests
    avm_readdatavalid = 1; avm_readdata = 32'hDEADBEEF;
    tick();
    avm_readdatavalid = 0;
    chkb("stray_prot", err_protocol, 1'b1);
    chkb("stray_dv", sdram_datareadvalid, 1'b0);
    chk("stray_data_hold", data_sdram, fmt(d3));
    n_rst = 0;
    tick();
    n_rst = 1;
    chkb("prot_cleared", err_protocol, 1'b0);
    sdram_read_en = 1; sdram_write_en = 1; address_sdram = 26'd7;
    tick();
    sdram_read_en = 0; sdram_write_en = 0;
    chkb("both_prot", err_protocol, 1'b1);
    chkb("both_busy", busy, 1'b0);
    #1;
    chkb("both_rd", avm_read, 1'b0);
    chkb("both_wr", avm_write, 1'b0);

    // Reset with two reads outstanding
    sdram_read_en = 1; address_sdram = 26'h30;
    tick();
    sdram_read_en = 0;
    tick();
    avm_readdatavalid = 1; avm_readdata = 32'h13572468;
    tick();
    avm_readdatavalid = 0;
    sdram_read_en = 1; address_sdram = 26'h31;
    tick();
    address_sdram = 26'h32;
    tick();
    sdram_read_en = 0;
    tick();
    chkb("rmid_busy", busy, 1'b1);
    chk("rmid_data", data_sdram, fmt(32'h13572468));
    n_rst = 0;
    tick();
    all_zero("rmid");
    n_rst = 1;

    // Randomized traffic against the transaction model
    for (int i = 0; i < 600; i++) rcycle(1'b1);
    for (int i = 0; i < 200 && (mq.size() != 0 || rq.size() != 0 || out_cnt != 0); i++)
      rcycle(1'b0);
    chkb("rnd_drained", (mq.size() == 0) && (rq.size() == 0) && (out_cnt == 0), 1'b1);
    rcycle(1'b0);
    chkb("rnd_ovf_clean", err_overflow, 1'b0);
    chkb("rnd_prot_clean", err_protocol, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
